// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: HI/LO owner with multi-cycle multiply/accumulate and restoring divide sequencer
module hilo_mdu_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [12:0] req_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        stall,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam logic [2:0] IDLE = 3'd0, MUL = 3'd1, ACC = 3'd2, DIV_PRE = 3'd3, DIV_ITER = 3'd4, DIV_POST = 3'd5;
  logic [2:0] state, state_nx;
  logic [12:0] op_lo;
  logic [31:0] a_r, b_r, hi, lo, div_q, div_r, diff;
  logic [63:0] prod, ext_a, ext_b, acc;
  logic [32:0] trial;
  logic [4:0] cnt;
  logic idle, accept, div_s, mul_only, sgn, add_op, sub_op, q_neg, r_neg, ge;
  assign op_lo = req_op & (~req_op + 13'd1);
  assign idle = state == IDLE;
  assign accept = req_valid & idle & ~flush;
  assign req_ready = idle;
  assign resp_valid = ~flush & (idle ? req_valid & (|op_lo[3:0] | ~|req_op) : (state == ACC) | (state == DIV_POST));
  assign resp_data = ~resp_valid ? 32'd0 : idle ? (op_lo[2] ? hi : op_lo[3] ? lo : 32'd0) : (state == ACC && mul_only) ? prod[31:0] : 32'd0;
  assign stall = req_valid & ~resp_valid & ~flush;
  assign hi_o = hi;
  assign lo_o = lo;
  assign ext_a = {{32{sgn & a_r[31]}}, a_r};
  assign ext_b = {{32{sgn & b_r[31]}}, b_r};
  assign acc = add_op ? {hi, lo} + prod : sub_op ? {hi, lo} - prod : prod;
  assign trial = {prod[63:32], prod[31]};
  assign ge = trial >= {1'b0, b_r};
  assign diff = trial[31:0] - b_r;
  assign div_q = b_r == 32'd0 ? 32'hFFFF_FFFF : q_neg ? -prod[31:0] : prod[31:0];
  assign div_r = b_r == 32'd0 ? a_r : r_neg ? -prod[63:32] : prod[63:32];
  assign state_nx = flush ? IDLE :
                    idle ? (~accept ? IDLE : |op_lo[12:6] ? MUL : |op_lo[5:4] ? DIV_PRE : IDLE) :
                    state == MUL ? ACC :
                    state == DIV_PRE ? DIV_ITER :
                    state == DIV_ITER ? (cnt == 5'd31 ? DIV_POST : DIV_ITER) : IDLE;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      hi <= '0;
      lo <= '0;
      prod <= '0;
      cnt <= '0;
      div_s <= 1'b0;
      mul_only <= 1'b0;
      sgn <= 1'b0;
      add_op <= 1'b0;
      sub_op <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_r <= src_a;
        b_r <= src_b;
        div_s <= op_lo[4];
        mul_only <= op_lo[8];
        sgn <= op_lo[6] | op_lo[8] | op_lo[9] | op_lo[11];
        add_op <= op_lo[9] | op_lo[10];
        sub_op <= op_lo[11] | op_lo[12];
      end
      if (accept & op_lo[0]) hi <= src_a;
      if (accept & op_lo[1]) lo <= src_a;
      if (state == MUL) prod <= ext_a * ext_b;
      if (state == ACC && !flush && !mul_only) {hi, lo} <= acc;
      if (state == DIV_PRE) begin
        q_neg <= div_s & (a_r[31] ^ b_r[31]);
        r_neg <= div_s & a_r[31];
        prod <= {32'd0, div_s & a_r[31] ? -a_r : a_r};
        b_r <= div_s & b_r[31] ? -b_r : b_r;
        cnt <= '0;
      end
      if (state == DIV_ITER) begin
        prod <= {ge ? diff : trial[31:0], prod[30:0], ge};
        cnt <= cnt + 5'd1;
      end
      if (state == DIV_POST && !flush) begin
        lo <= div_q;
        hi <= div_r;
      end
    end
endmodule
